// File: rtl/conv2d_mac_engine.sv
// Single-MAC 2-D valid convolution over an image and a kernel that are streamed in.
// Each window's result leaves on a back-pressured stream, saturated or wrapped to OUT_W.
module conv2d_mac_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_N  = 4,
  parameter int unsigned K_N    = 3,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(K_N * K_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam int unsigned O_N    = IMG_N - K_N + 1;
  localparam int unsigned IMG_SZ = IMG_N * IMG_N;
  localparam int unsigned KER_SZ = K_N * K_N;
  localparam int unsigned TOTAL  = IMG_SZ + KER_SZ;
  localparam int unsigned LD_W   = $clog2(TOTAL + 1);
  localparam int unsigned IMG_AW = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1;
  localparam int unsigned KER_AW = (KER_SZ > 1) ? $clog2(KER_SZ) : 1;
  localparam int unsigned CNT_W  = $clog2(IMG_N + 1);
  localparam int unsigned WIDE_W = ACC_W + OUT_W;

  if (K_N > IMG_N) begin : g_bad_kernel
    $error("conv2d_mac_engine: K_N must not exceed IMG_N");
  end
  if (ACC_W != 2 * DATA_W + $clog2(KER_SZ)) begin : g_bad_acc
    $error("conv2d_mac_engine: ACC_W is derived and must not be overridden");
  end

  typedef enum logic [2:0] {StLoad, StIdle, StMac, StOut, StDone} state_e;

  state_e              state_q, state_d;
  logic [LD_W-1:0]     ld_cnt_q;
  logic [DATA_W-1:0]   img_q [IMG_SZ];
  logic [DATA_W-1:0]   ker_q [KER_SZ];
  logic [CNT_W-1:0]    wr_q, wc_q, kr_q, kc_q;
  logic [ACC_W-1:0]    acc_q;
  logic                sat_q;
  logic                out_valid_q, out_last_q, busy_q, done_q, ovf_q;
  logic [OUT_W-1:0]    out_data_q;

  logic                ld_fire, ld_last, ld_to_img, kern_last, kc_last, win_last, wc_last;
  logic [IMG_AW-1:0]   img_ra, img_wa;
  logic [KER_AW-1:0]   ker_ra, ker_wa;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_next;
  logic [WIDE_W-1:0]   acc_wide;
  logic                acc_over;
  logic [OUT_W-1:0]    narrow;

  always_comb begin
    img_ra    = IMG_AW'((32'(wr_q) + 32'(kr_q)) * IMG_N + 32'(wc_q) + 32'(kc_q));
    ker_ra    = KER_AW'(32'(kr_q) * K_N + 32'(kc_q));
    // A word taken in idle restarts the load sequence at image[0].
    ld_to_img = (state_q == StIdle) || (ld_cnt_q < LD_W'(IMG_SZ));
    img_wa    = (state_q == StIdle) ? '0 : IMG_AW'(ld_cnt_q);
    ker_wa    = KER_AW'(ld_cnt_q - LD_W'(IMG_SZ));
    ld_last   = ld_cnt_q == LD_W'(TOTAL - 1);
    kc_last   = kc_q == CNT_W'(K_N - 1);
    kern_last = kc_last && (kr_q == CNT_W'(K_N - 1));
    wc_last   = wc_q == CNT_W'(O_N - 1);
    win_last  = wc_last && (wr_q == CNT_W'(O_N - 1));
    prod      = (2 * DATA_W)'(img_q[img_ra]) * (2 * DATA_W)'(ker_q[ker_ra]);
    acc_next  = acc_q + ACC_W'(prod);
    acc_wide  = WIDE_W'(acc_next);
    acc_over  = |(acc_wide >> OUT_W);
    narrow    = (sat_q && acc_over) ? '1 : acc_wide[OUT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    case (state_q)
      StLoad: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = StIdle;
      end
      StIdle: begin
        ld_ready = !start;
        if (start)         state_d = StMac;
        else if (ld_valid) state_d = StLoad;
      end
      StMac:  if (kern_last) state_d = StOut;
      StOut:  if (out_ready) state_d = win_last ? StDone : StMac;
      StDone: state_d = StIdle;
      default: state_d = StLoad;
    endcase
  end

  assign ld_fire = ld_valid && ld_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StLoad;
    else     state_q <= state_d;
  end

  // Buffer contents are not reset; a reload always follows reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (ld_to_img) img_q[img_wa] <= ld_data;
      else           ker_q[ker_wa] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q    <= '0;
      wr_q        <= '0;
      wc_q        <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (ld_fire) ld_cnt_q <= (state_q == StIdle) ? LD_W'(1) : ld_cnt_q + LD_W'(1);
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q <= '0;
            wr_q  <= '0;
            wc_q  <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
            ovf_q <= 1'b0;
            sat_q <= sat_en;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          if (kc_last) begin
            kc_q <= '0;
            kr_q <= kern_last ? '0 : kr_q + CNT_W'(1);
          end else begin
            kc_q <= kc_q + CNT_W'(1);
          end
          // The final product of the window goes straight into the output register.
          if (kern_last) begin
            out_data_q <= narrow;
            out_last_q <= win_last;
            if (acc_over) ovf_q <= 1'b1;
          end
        end
        StOut: begin
          if (out_ready && !win_last) begin
            acc_q <= '0;
            if (wc_last) begin
              wc_q <= '0;
              wr_q <= wr_q + CNT_W'(1);
            end else begin
              wc_q <= wc_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
      out_valid_q <= state_d == StOut;
      busy_q      <= state_d inside {StMac, StOut, StDone};
      done_q      <= state_d == StDone;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
endmodule
